// File: rtl/gray_ctrl_pkg.sv
// Shared definitions for the Gray-coded stepping position controller.
//   POS_W   : width of the position / Gray code (3 bits, 8 positions)
//   state_t : controller states IDLE, RUN, DONE
package gray_ctrl_pkg;
   localparam int POS_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/bin_to_gray.sv
// 3-bit binary to Gray code converter, purely combinational.
//   bin  : binary input
//   gray : Gray code output (g2=b2, g1=b1^b2, g0=b0^b1)
module bin_to_gray
   import gray_ctrl_pkg::*;
(
   input  logic [POS_W-1:0] bin,
   output logic [POS_W-1:0] gray
);
   assign gray = {bin[2], bin[2] ^ bin[1], bin[1] ^ bin[0]};
endmodule

// File: rtl/gray_step_ctrl.sv
// Stepping position controller: moves a 3-bit position one step every
// STEP_DIV cycles in a fixed direction until it reaches a target.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : request a move (only looked at in IDLE)
//   dir    : 1 = up (+1), 0 = down (-1), captured with start
//   target : destination position, captured with start
//   abort  : cancel a move in progress (RUN only)
//   pos    : current position (registered)
//   gray   : Gray code of pos
//   busy   : high in RUN
//   step   : one-cycle pulse when the position advances
//   done   : one-cycle pulse when a move completes
module gray_step_ctrl
   import gray_ctrl_pkg::*;
#(
   parameter int STEP_DIV = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             dir,
   input  logic [POS_W-1:0] target,
   input  logic             abort,
   output logic [POS_W-1:0] pos,
   output logic [POS_W-1:0] gray,
   output logic             busy,
   output logic             step,
   output logic             done
);
   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(STEP_DIV - 1);

   state_t           state, state_nxt;
   logic [POS_W-1:0] pos_q, pos_nxt;
   logic [POS_W-1:0] tgt_q, tgt_nxt;
   logic             dir_q, dir_nxt;
   logic [DIV_W-1:0] div_q, div_nxt;
   logic [POS_W-1:0] pos_stepped;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pos_q <= '0;
         tgt_q <= '0;
         dir_q <= 1'b0;
         div_q <= '0;
      end else begin
         state <= state_nxt;
         pos_q <= pos_nxt;
         tgt_q <= tgt_nxt;
         dir_q <= dir_nxt;
         div_q <= div_nxt;
      end
   end

   // 3-bit arithmetic wraps naturally: 7+1 -> 0, 0-1 -> 7
   assign pos_stepped = dir_q ? pos_q + 3'd1 : pos_q - 3'd1;

   always_comb begin
      state_nxt = state;
      pos_nxt   = pos_q;
      tgt_nxt   = tgt_q;
      dir_nxt   = dir_q;
      div_nxt   = div_q;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (target == pos_q) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = RUN;
                  tgt_nxt   = target;
                  dir_nxt   = dir;
                  div_nxt   = '0;
               end
            end
         end
         RUN: begin
            // abort beats a coincident terminal count: no step, pos held
            if (abort) begin
               state_nxt = IDLE;
               div_nxt   = '0;
            end else if (div_q == DIV_TC) begin
               step    = 1'b1;
               pos_nxt = pos_stepped;
               div_nxt = '0;
               if (pos_stepped == tgt_q) state_nxt = DONE;
            end else begin
               div_nxt = div_q + DIV_W'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign pos  = pos_q;
   assign busy = (state == RUN);
   assign done = (state == DONE);

   bin_to_gray u_b2g (
      .bin  (pos_q),
      .gray (gray)
   );
endmodule

// File: tb/tb_gray_step_ctrl.sv
module tb_gray_step_ctrl;
   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst_n, start, dir, abort;
   logic [2:0] target, pos, gray;
   logic       busy, step, done;

   always #5 clk = ~clk;

   gray_step_ctrl #(.STEP_DIV(SD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .target(target),
      .abort(abort), .pos(pos), .gray(gray), .busy(busy), .step(step), .done(done)
   );

   int n_tot = 0, n_pass = 0;

   // reference model: m_st 0=idle 1=moving 2=done-pulse; m_el counts cycles since start edge
   int         m_st, m_el;
   logic [2:0] m_pos, m_tgt;
   logic       m_dir;

   logic [2:0] s_pos, s_gray;
   logic       s_busy, s_step, s_done;
   int         step_q[$];

   typedef struct {
      logic rst_n, start, dir; logic [2:0] tgt; logic abort;
      logic [2:0] pos; logic busy, step, done;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [2:0] to_gray(input logic [2:0] p);
      return p ^ (p >> 1);
   endfunction

   task automatic tick(input logic r, input logic s, input logic d, input logic [2:0] t, input logic a);
      logic e_step;
      rst_n = r; start = s; dir = d; target = t; abort = a;
      @(negedge clk);
      s_pos = pos; s_gray = gray; s_busy = busy; s_step = step; s_done = done;
      e_step = (m_st == 1) && (m_el % SD == 0) && !a;
      chk("model_pos",  32'(s_pos),  32'(m_pos));
      chk("model_gray", 32'(s_gray), 32'(to_gray(m_pos)));
      chk("model_busy", 32'(s_busy), 32'(m_st == 1));
      chk("model_step", 32'(s_step), 32'(e_step));
      chk("model_done", 32'(s_done), 32'(m_st == 2));
      @(posedge clk); #1;
      if (!r) begin
         m_st = 0; m_pos = 0; m_tgt = 0; m_dir = 0; m_el = 0;
      end else begin
         case (m_st)
            0: if (s) begin
                  if (t == m_pos) m_st = 2;
                  else begin m_st = 1; m_tgt = t; m_dir = d; m_el = 1; end
               end
            1: if (a) m_st = 0;
               else begin
                  if (e_step) begin
                     m_pos = 3'((int'(m_pos) + (m_dir ? 1 : 7)) % 8);
                     if (m_pos == m_tgt) m_st = 2;
                  end
                  m_el++;
               end
            default: m_st = 0;
         endcase
      end
   endtask

   task automatic do_reset();
      rst_n = 0; start = 0; dir = 0; target = 0; abort = 0;
      @(posedge clk); #1;
      m_st = 0; m_pos = 0; m_tgt = 0; m_dir = 0; m_el = 0;
   endtask

   // runs idle cycles after a start edge; optional abort once nst==ab_step,
   // optional stray start (down, poke_t) at cycle poke_c
   task automatic run(input int lim, input int ab_step, input int poke_c, input logic [2:0] poke_t,
                      output int nst, output int dcyc, output int ndone);
      nst = 0; dcyc = -1; ndone = 0;
      for (int c = 1; c <= lim; c++) begin
         logic a;
         a = (ab_step > 0) && (nst == ab_step);
         tick(1'b1, c == poke_c, 1'b0, poke_t, a);
         if (s_step) begin nst++; step_q.push_back(c); end
         if (s_done) begin ndone++; dcyc = c; end
         if (a || s_done) break;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nst, dc, nd, cnt;
      //          rst start dir tgt  abort  pos  busy step done
      tbl[0]  = '{1, 0, 0, 3'd0, 0, 3'd0, 0, 0, 0};
      tbl[1]  = '{1, 1, 1, 3'd0, 0, 3'd0, 0, 0, 0};
      tbl[2]  = '{1, 0, 0, 3'd0, 0, 3'd0, 0, 0, 1};
      tbl[3]  = '{1, 0, 0, 3'd0, 0, 3'd0, 0, 0, 0};
      tbl[4]  = '{1, 0, 0, 3'd0, 1, 3'd0, 0, 0, 0};
      tbl[5]  = '{1, 1, 1, 3'd1, 0, 3'd0, 0, 0, 0};
      tbl[6]  = '{1, 0, 0, 3'd0, 0, 3'd0, 1, 0, 0};
      tbl[7]  = '{1, 0, 0, 3'd0, 0, 3'd0, 1, 0, 0};
      tbl[8]  = '{1, 0, 0, 3'd0, 0, 3'd0, 1, 0, 0};
      tbl[9]  = '{1, 0, 0, 3'd0, 0, 3'd0, 1, 1, 0};
      tbl[10] = '{1, 0, 0, 3'd0, 0, 3'd1, 0, 0, 1};
      tbl[11] = '{1, 0, 0, 3'd0, 0, 3'd1, 0, 0, 0};

      do_reset();
      foreach (tbl[i]) begin
         tick(tbl[i].rst_n, tbl[i].start, tbl[i].dir, tbl[i].tgt, tbl[i].abort);
         chk($sformatf("tbl%0d_pos", i),  32'(s_pos),  32'(tbl[i].pos));
         chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
         chk($sformatf("tbl%0d_step", i), 32'(s_step), 32'(tbl[i].step));
         chk($sformatf("tbl%0d_done", i), 32'(s_done), 32'(tbl[i].done));
      end

      // 0 -> 3 up: steps at 4, 8, 12, done at 13
      do_reset();
      tick(1, 0, 0, 0, 0);
      chk("rst_gray", 32'(s_gray), 0);
      step_q.delete();
      tick(1, 1, 1, 3'd3, 0);
      run(20, 0, 0, 0, nst, dc, nd);
      chk("up3_nsteps", nst, 3);
      chk("up3_nstepq", step_q.size(), 3);
      foreach (step_q[i]) chk($sformatf("up3_stepcyc%0d", i), step_q[i], 4 * (i + 1));
      chk("up3_done_cyc", dc, 13);
      chk("up3_pos", 32'(s_pos), 3);
      chk("up3_gray", 32'(s_gray), 32'(3'b010));
      tick(1, 0, 0, 0, 0);
      chk("up3_busy_after", 32'(s_busy), 0);

      // 3 -> 7 up with a stray start mid-move
      tick(1, 1, 1, 3'd7, 0);
      run(30, 0, 5, 3'd0, nst, dc, nd);
      chk("ign_nsteps", nst, 4);
      chk("ign_done_cyc", dc, 17);
      chk("ign_ndone", nd, 1);
      chk("ign_pos", 32'(s_pos), 7);
      tick(1, 0, 0, 0, 0);
      chk("ign_no_redone", 32'(s_done), 0);

      // 0 -> 4 up aborted after 2nd step, then resume 2 -> 4
      do_reset();
      tick(1, 1, 1, 3'd4, 0);
      run(30, 2, 0, 0, nst, dc, nd);
      chk("abort_nsteps", nst, 2);
      chk("abort_ndone", nd, 0);
      chk("abort_step_in_abort_cyc", 32'(s_step), 0);
      tick(1, 0, 0, 0, 0);
      chk("abort_pos", 32'(s_pos), 2);
      chk("abort_busy", 32'(s_busy), 0);
      chk("abort_done", 32'(s_done), 0);
      tick(1, 1, 1, 3'd4, 0);
      run(20, 0, 0, 0, nst, dc, nd);
      chk("resume_nsteps", nst, 2);
      chk("resume_done_cyc", dc, 9);
      chk("resume_pos", 32'(s_pos), 4);

      // move to 5, then start with target==pos
      tick(1, 1, 1, 3'd5, 0);
      run(10, 0, 0, 0, nst, dc, nd);
      chk("to5_pos", 32'(s_pos), 5);
      tick(1, 1, 0, 3'd5, 0);
      chk("same_busy", 32'(s_busy), 0);
      run(5, 0, 0, 0, nst, dc, nd);
      chk("same_done_cyc", dc, 1);
      chk("same_nsteps", nst, 0);

      // 1 -> 6 down through the wrap
      do_reset();
      tick(1, 1, 1, 3'd1, 0);
      run(10, 0, 0, 0, nst, dc, nd);
      tick(1, 1, 0, 3'd6, 0);
      run(20, 0, 0, 0, nst, dc, nd);
      chk("down_nsteps", nst, 3);
      chk("down_done_cyc", dc, 13);
      chk("down_pos", 32'(s_pos), 6);
      chk("down_gray", 32'(s_gray), 32'(3'b101));

      // reset mid-move at pos 3
      do_reset();
      tick(1, 1, 1, 3'd7, 0);
      cnt = 0;
      for (int c = 0; c < 20 && cnt < 3; c++) begin
         tick(1, 0, 0, 0, 0);
         if (s_step) cnt++;
      end
      chk("mid_nsteps", cnt, 3);
      tick(1, 0, 0, 0, 0);
      chk("mid_pos", 32'(s_pos), 3);
      tick(0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      chk("mid_rst_pos", 32'(s_pos), 0);
      chk("mid_rst_gray", 32'(s_gray), 0);
      chk("mid_rst_busy", 32'(s_busy), 0);
      chk("mid_rst_done", 32'(s_done), 0);
      tick(1, 1, 1, 3'd2, 0);
      run(20, 0, 0, 0, nst, dc, nd);
      chk("mid_after_done_cyc", dc, 9);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         tick($urandom_range(49) != 0, $urandom_range(3) == 0, 1'($urandom_range(1)),
              3'($urandom_range(7)), $urandom_range(15) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/gray_step_ctrl.md
GRAY_STEP_CTRL -- requirements
Module: gray_step_ctrl

Interface
REQ-001 SHALL have parameter STEP_DIV, default 4, meaning clock cycles per position step (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port start, input, 1, request a move; sampled only in IDLE.
REQ-005 SHALL have port dir, input, 1, move direction captured with start: 1 = up (+1), 0 = down (-1).
REQ-006 SHALL have port target, input, 3, destination position (binary), captured with start.
REQ-007 SHALL have port abort, input, 1, cancels a move in progress.
REQ-008 SHALL have port pos, output, 3, current position (binary, registered).
REQ-009 SHALL have port gray, output, 3, Gray code of pos (g2=p2, g1=p1^p2, g0=p0^p1), combinational from the pos register.
REQ-010 SHALL have port busy, output, 1, high while in RUN.
REQ-011 SHALL have port step, output, 1, one-cycle pulse on each divider terminal count in RUN.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when a move completes.

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE.
REQ-014 IDLE, start=1, target!=pos: SHALL latch target and dir, clear the divider, and enter RUN next cycle.
REQ-015 IDLE, start=1, target==pos: SHALL enter DONE next cycle with no step.
REQ-016 RUN: divider SHALL count 0..STEP_DIV-1; at terminal count, step=1 and pos SHALL update by ±1 at that edge (visible the next cycle); the divider SHALL wrap to 0.
REQ-017 Position arithmetic SHALL be modulo 8: up from 7 gives 0, down from 0 gives 7; the move always takes dir, never the shorter path.
REQ-018 If the stepped pos equals the latched target, the same edge SHALL enter DONE, so done=1 in the first cycle that pos==target.
REQ-019 DONE SHALL last exactly one cycle (done=1, busy=0), then return to IDLE.
REQ-020 abort=1 in RUN SHALL return to IDLE next cycle with pos held, no step that cycle, and no done; abort outside RUN SHALL be ignored.
REQ-021 start while in RUN or DONE SHALL be ignored (not queued).
REQ-022 abort and terminal count in the same cycle: abort SHALL win; pos is not updated.
REQ-023 step and done SHALL never be high outside RUN and DONE respectively.
REQ-024 Latency SHALL be STEP_DIV*N + 1 cycles from the start-sampling edge to the done pulse, for a move of N steps.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, pos=0 (gray=000), divider=0, latched target/dir=0, busy=0, step=0 and done=0, including mid-move.
REQ-026 Outputs SHALL show reset values in the first cycle after the reset edge; start SHALL be honoured from the first edge with rst_n=1.

Structure
REQ-027 Package gray_ctrl_pkg SHALL hold POS_W=3 and the state enum type (IDLE, RUN, DONE).
REQ-028 Binary-to-Gray conversion SHALL be a separate sub-module bin_to_gray (3-bit, combinational), instantiated once on pos.
REQ-029 The divider width SHALL be derived from STEP_DIV (clog2, minimum 1 bit).

Verification (STEP_DIV=4)
REQ-030 Reset, pos=0; start, dir=1, target=3 -> step at cycles 4, 8 and 12 after the start edge; gray 000→001→011→010; done once with pos=3; busy low after.
REQ-031 pos=1; start, dir=0, target=6 -> wrap 1→0→7→6; gray 001→000→100→101; exactly 3 steps then done.
REQ-032 pos=5; start, target=5 -> done the next cycle; no step; busy stays 0.
REQ-033 Move 0→4 up; abort after the 2nd step -> pos=2 held; IDLE; no done; a new start 2→4 completes in 2 steps.
REQ-034 start pulsed during RUN with a different target -> ignored; original target reached; single done.
REQ-035 rst_n=0 mid-move at pos=3 -> next cycle pos=0, gray=000, busy=0, no done; the following start behaves normally.
